// File: rtl/snoop_tx_pkg.sv
// Shared types for the snoop-invalidate transmit path: request record, FSM states, line extraction.
// No logic of its own; line size follows the data-cache sub-line geometry.
// Not applicable (package).
package snoop_types;

  // 8-word data-cache lines: 3 sub-line word-address bits below the line address
  localparam int DCACHE_SUB_LINE_ADDR_W = 3;
  localparam int SNOOP_LINE_W           = 32 - 2 - DCACHE_SUB_LINE_ADDR_W;

  typedef struct packed {
    logic [31:0] addr;
    logic        wnr;
  } snoop_req_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DRAIN_DONE
  } snoop_tx_state_t;

  function automatic logic [SNOOP_LINE_W-1:0] getSnoopLine(input logic [31:0] addr);
    return addr[31:2+DCACHE_SUB_LINE_ADDR_W];
  endfunction

endpackage

// File: rtl/snoop_tx_fifo.sv
// Snoop request buffer: storage, wrapping pointers, occupancy count, per-entry valid/line view.
// Latency: a push is visible at the head one cycle later; push and pop in one cycle leave count unchanged.
// Backpressure: none internally; the caller must not push when full nor pop when empty.
module snoop_fifo
  import snoop_types::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               push,
  input  snoop_req_t                         push_dat,
  input  logic                               pop,
  output snoop_req_t                         head_dat,
  output logic [CNT_W-1:0]                   count,
  output logic                               full,
  output logic                               empty,
  output logic [DEPTH-1:0]                   ent_vld,
  output logic [DEPTH-1:0]                   head_oh,
  output logic [DEPTH-1:0]                   ent_wnr,
  output logic [DEPTH-1:0][SNOOP_LINE_W-1:0] ent_line
);

  snoop_req_t        mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  offs;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);

  // An entry is live when its distance from the read pointer is below the occupancy
  always_comb begin
    offs     = '0;
    ent_vld  = '0;
    head_oh  = '0;
    ent_wnr  = '0;
    ent_line = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs        = PTR_W'(i) - rd_ptr;
      ent_vld[i]  = (CNT_W'(offs) < count);
      head_oh[i]  = (PTR_W'(i) == rd_ptr);
      ent_wnr[i]  = mem[i].wnr;
      ent_line[i] = getSnoopLine(mem[i].addr);
    end
  end

endmodule

// File: rtl/snoop_tx.sv
// Snoop-invalidate transmitter: buffers committed store addresses and hands them to the peer one per ack.
// Latency: accepted store appears on wvalid the next cycle; one transfer per cycle under continuous ack.
// Backpressure: st_ready low when full or a drain is pending. SNOOP_COALESCE_EN drops same-line repeats.
module snoop_tx
  import snoop_types::*;
#(
  parameter  int SNOOP_FIFO_DEPTH = 4,
  localparam int SNOOP_CNT_W      = $clog2(SNOOP_FIFO_DEPTH + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic        st_wnr,
  output logic        st_ready,
  output logic [31:0] snoopy_addr,
  output logic        wvalid,
  output logic        wnr,
  input  logic        snoop_ack,
  input  logic        drain_req,
  output logic        drain_done,
  output logic        idle
);

  snoop_tx_state_t                               state, state_nxt;
  snoop_req_t                                    head_dat;
  logic [SNOOP_CNT_W-1:0]                        count, count_nxt;
  logic                                          full, empty;
  logic                                          push, pop, coal_hit;
  logic                                          drain_pend, draining;
  logic [SNOOP_FIFO_DEPTH-1:0]                   ent_vld, head_oh, ent_wnr;
  logic [SNOOP_FIFO_DEPTH-1:0][SNOOP_LINE_W-1:0] ent_line;

  snoop_fifo #(.DEPTH(SNOOP_FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat ('{addr: st_addr, wnr: st_wnr}),
    .pop      (pop),
    .head_dat (head_dat),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .ent_vld  (ent_vld),
    .head_oh  (head_oh),
    .ent_wnr  (ent_wnr),
    .ent_line (ent_line)
  );

`ifdef SNOOP_COALESCE_EN
  // The head may already be mid-handshake with the peer, so it never absorbs a repeat
  always_comb begin
    coal_hit = 1'b0;
    for (int i = 0; i < SNOOP_FIFO_DEPTH; i++) begin
      if (ent_vld[i] && !head_oh[i] && ent_wnr[i] == st_wnr &&
          ent_line[i] == getSnoopLine(st_addr))
        coal_hit = 1'b1;
    end
  end
`else
  logic unused_coal;
  assign unused_coal = ^{ent_vld, head_oh, ent_wnr, ent_line};
  assign coal_hit    = 1'b0;
`endif

  assign st_ready    = !full && !drain_pend;
  assign push        = st_valid && st_ready && !coal_hit;
  assign pop         = wvalid && snoop_ack;
  assign wvalid      = (state == SEND);
  assign drain_done  = (state == DRAIN_DONE);
  assign idle        = empty && (state != SEND);
  assign snoopy_addr = head_dat.addr;
  assign wnr         = head_dat.wnr;
  assign draining    = drain_pend || drain_req;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + SNOOP_CNT_W'(1);
      2'b01:   count_nxt = count - SNOOP_CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (count_nxt != '0)  state_nxt = SEND;
        else if (draining)    state_nxt = DRAIN_DONE;
      end
      SEND: begin
        if (snoop_ack && count_nxt == '0)
          state_nxt = draining ? DRAIN_DONE : IDLE;
      end
      DRAIN_DONE: state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      drain_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      drain_pend <= drain_done ? 1'b0 : draining;
    end
  end

endmodule

// File: tb/tb_snoop_tx.sv
// Scoreboard bench for snoop_tx: expected snoops queued on acceptance, compared on each peer ack.
// Build with +define+SNOOP_COALESCE_EN to exercise coalescing expectations.
module tb_snoop_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic        st_wnr;
  logic        st_ready;
  logic [31:0] snoopy_addr;
  logic        wvalid;
  logic        wnr;
  logic        snoop_ack;
  logic        drain_req;
  logic        drain_done;
  logic        idle;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_pop_cyc = -1;

  typedef struct {
    logic [31:0] addr;
    logic        wnr;
  } exp_t;
  exp_t exp_q[$];

  snoop_tx #(.SNOOP_FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .st_valid    (st_valid),
    .st_addr     (st_addr),
    .st_wnr      (st_wnr),
    .st_ready    (st_ready),
    .snoopy_addr (snoopy_addr),
    .wvalid      (wvalid),
    .wnr         (wnr),
    .snoop_ack   (snoop_ack),
    .drain_req   (drain_req),
    .drain_done  (drain_done),
    .idle        (idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Model enqueue; with coalescing, a same-line same-wnr match on any non-head entry drops it
  task automatic model_push(input logic [31:0] a, input logic w);
    bit drop = 1'b0;
`ifdef SNOOP_COALESCE_EN
    for (int j = 1; j < exp_q.size(); j++)
      if (exp_q[j].wnr == w && exp_q[j].addr[31:5] == a[31:5]) drop = 1'b1;
`endif
    if (!drop) exp_q.push_back('{addr: a, wnr: w});
  endtask

  // Record the transfers that the coming edge will perform, then advance one cycle
  task automatic tick();
    exp_t e;
    #1;
    if (st_valid && st_ready) model_push(st_addr, st_wnr);
    if (wvalid && snoop_ack) begin
      chk("pop_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_addr", snoopy_addr, e.addr);
        chk("sb_wnr", 32'(wnr), 32'(e.wnr));
      end
      last_pop_cyc = cyc;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic store(input logic [31:0] a, input logic w);
    st_valid = 1'b1;
    st_addr  = a;
    st_wnr   = w;
    tick();
    st_valid = 1'b0;
  endtask

  task automatic flush();
    snoop_ack = 1'b1;
    for (int k = 0; k < 20 && !idle; k++) tick();
    snoop_ack = 1'b0;
    chk("flush_idle", 32'(idle), 32'd1);
    chk("flush_sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int pulses;
    int done_at;
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_wnr = 1'b0;
    snoop_ack = 1'b0; drain_req = 1'b0;
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_wvalid", 32'(wvalid), 32'd0);
    chk("rst_drain_done", 32'(drain_done), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_addr", snoopy_addr, 32'd0);
    chk("rst_wnr", 32'(wnr), 32'd0);

    // Single store, peer acks two cycles after wvalid rises
    store(32'h8000_0040, 1'b1);
    chk("single_wvalid", 32'(wvalid), 32'd1);
    chk("single_addr", snoopy_addr, 32'h8000_0040);
    tick();
    chk("single_hold1", snoopy_addr, 32'h8000_0040);
    tick();
    chk("single_hold2", snoopy_addr, 32'h8000_0040);
    chk("single_wnr", 32'(wnr), 32'd1);
    snoop_ack = 1'b1;
    tick();
    snoop_ack = 1'b0;
    chk("single_wvalid_drop", 32'(wvalid), 32'd0);
    chk("single_idle", 32'(idle), 32'd1);

    // Five back-to-back stores into a depth-4 FIFO with ack held low
    for (int i = 0; i < 5; i++) begin
      st_valid = 1'b1;
      st_addr  = 32'h0000_1000 + 32'(i) * 32'h40;
      st_wnr   = i[0];
      #1 chk($sformatf("fill_ready%0d", i), 32'(st_ready), 32'(i < 4));
      tick();
    end
    snoop_ack = 1'b1;
    tick();
    chk("fifth_ready_after_pop", 32'(st_ready), 32'd1);
    tick();
    st_valid = 1'b0;
    flush();

    // Push and pop in the same cycle at count 2, then confirm count stayed 2
    store(32'h0000_2000, 1'b1);
    store(32'h0000_2040, 1'b0);
    st_valid = 1'b1; st_addr = 32'h0000_2080; st_wnr = 1'b1; snoop_ack = 1'b1;
    tick();
    st_valid = 1'b0; snoop_ack = 1'b0;
    store(32'h0000_20c0, 1'b0);
    chk("pp_count3_ready", 32'(st_ready), 32'd1);
    store(32'h0000_2100, 1'b1);
    chk("pp_count4_full", 32'(st_ready), 32'd0);
    flush();

    // Drain with three entries queued and ack every cycle
    store(32'h0000_3000, 1'b1);
    store(32'h0000_3040, 1'b1);
    store(32'h0000_3080, 1'b0);
    drain_req = 1'b1; snoop_ack = 1'b1;
    tick();
    drain_req = 1'b0;
    chk("drain_block", 32'(st_ready), 32'd0);
    pulses = 0; done_at = -1;
    for (int k = 0; k < 8; k++) begin
      if (drain_done) begin pulses++; done_at = cyc; end
      if (pulses == 0) chk($sformatf("drain_block%0d", k), 32'(st_ready), 32'd0);
      tick();
    end
    snoop_ack = 1'b0;
    chk("drain_pulses", 32'(pulses), 32'd1);
    chk("drain_timing", 32'(done_at), 32'(last_pop_cyc + 1));
    chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_release", 32'(st_ready), 32'd1);

    // Drain on an empty FIFO completes the next cycle
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    chk("drain_empty_pulse", 32'(drain_done), 32'd1);
    tick();
    chk("drain_empty_once", 32'(drain_done), 32'd0);
    chk("drain_empty_ready", 32'(st_ready), 32'd1);

    // Same-line stores with ack held low: 0x204 shares 0x200's line, 0x100 only matches the head
    store(32'h0000_0100, 1'b1);
    store(32'h0000_0200, 1'b1);
    store(32'h0000_0204, 1'b1);
    store(32'h0000_0100, 1'b1);
`ifdef SNOOP_COALESCE_EN
    chk("coal_count3_ready", 32'(st_ready), 32'd1);
    chk("coal_model_count", 32'(exp_q.size()), 32'd3);
`else
    chk("nocoal_count4_full", 32'(st_ready), 32'd0);
    chk("nocoal_model_count", 32'(exp_q.size()), 32'd4);
`endif
    flush();

    // Reset mid-transfer discards everything
    store(32'h0000_4000, 1'b1);
    store(32'h0000_4040, 1'b0);
    store(32'h0000_4080, 1'b1);
    chk("pre_rst_wvalid", 32'(wvalid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("mid_rst_wvalid", 32'(wvalid), 32'd0);
    chk("mid_rst_idle", 32'(idle), 32'd1);
    chk("mid_rst_ready", 32'(st_ready), 32'd1);
    chk("mid_rst_drain_done", 32'(drain_done), 32'd0);
    tick();
    chk("post_rst_quiet", 32'(wvalid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/snoop_tx.md
Name: snoop_tx

Overview:
- Transmit side of the inter-core snoop-invalidate interface. It sits on the writing core's store path, beside the load/store unit.
- Captures committed store addresses and buffers them in a small FIFO.
- Presents them one at a time to the peer core's data-tag banks on snoopy_addr/wvalid/wnr, using a valid/ack handshake.
- Provides store backpressure, plus a drain handshake so fences can wait until every pending invalidation has been accepted.

Parameters:
- SNOOP_FIFO_DEPTH, 4: number of buffered snoop requests; power of two, at least 2.
- SNOOP_CNT_W, $clog2(SNOOP_FIFO_DEPTH+1): width of the occupancy counter; derived, not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- st_valid  in  1  committed store/AMO request from the LSU
- st_addr  in  32  byte address of the request
- st_wnr  in  1  1 = write, 0 = read-type notification; forwarded unchanged
- st_ready  out  1  request accepted this cycle when st_valid & st_ready
- snoopy_addr  out  32  head-entry address presented to the peer
- wvalid  out  1  snoop request valid
- wnr  out  1  head-entry write-not-read flag
- snoop_ack  in  1  peer accepted the presented request
- drain_req  in  1  fence asks that the FIFO empty
- drain_done  out  1  one-cycle pulse when a drain completes
- idle  out  1  FIFO empty and no request in flight

Behaviour:
- Reset values: FIFO empty, count 0, state IDLE, wvalid 0, drain_done 0, idle 1, st_ready 1. snoopy_addr/wnr are 0 at reset and don't-care while wvalid=0.
- Accept rule: st_ready = (count != SNOOP_FIFO_DEPTH). There is no combinational pass-through. A push when full is not accepted, even if a pop happens in the same cycle.
- Push latency: a request accepted in cycle N is visible on wvalid/snoopy_addr no earlier than cycle N+1.
- Output rule: wvalid = (state == SEND). snoopy_addr and wnr are driven from the head entry.
  - snoopy_addr and wnr stay stable while wvalid=1 and snoop_ack=0.
  - snoop_ack while wvalid=0 is ignored.
- Pop: occurs on wvalid & snoop_ack. The next entry is presented in the following cycle, so back-to-back transfers are one per cycle.
- Simultaneous push and pop: count is unchanged and both take effect.
- Pointers: read and write pointers are log2(DEPTH) bits and wrap naturally. Count is kept separately to distinguish full from empty.
- FSM:
  - IDLE: enter SEND when count != 0 after the update. Stay in IDLE otherwise.
  - SEND: on ack, if count after the pop is 0, go to IDLE (or DRAIN_DONE if draining); otherwise stay in SEND.
  - DRAIN_DONE: assert drain_done for exactly one cycle, then go to IDLE.
- Drain tracking:
  - drain_req is sampled into a sticky drain_pend flag.
  - If drain_req arrives while the FIFO is empty and nothing is in flight, drain_done pulses in the next cycle.
  - While drain_pend=1, st_ready is forced to 0 so no new stores are admitted.
  - drain_pend clears when drain_done pulses.
- idle = (count == 0) & (state != SEND).
- Reset mid-transfer: all state is discarded, wvalid drops in the next cycle, and pending entries are lost. The peer must also be reset.

Optional Feature:
- Macro: SNOOP_COALESCE_EN.
- Defined:
  - An accepted request whose cache-line address matches any valid non-head entry with the same wnr is dropped, and count is unchanged.
  - Line address = st_addr[31:2+DCACHE_SUB_LINE_ADDR_W], using the taiga_config constants.
  - The head entry is never matched, because it may already be mid-handshake.
  - A coalesced request still counts as accepted (st_valid & st_ready).
- Undefined: every accepted request is enqueued.

Decomposition:
- Package snoop_types holds:
  - typedef snoop_req_t {addr[31:0], wnr};
  - enum snoop_tx_state_t {IDLE, SEND, DRAIN_DONE};
  - helper function getSnoopLine(addr).
- Natural sub-module snoop_fifo, which provides storage, pointers, count, full/empty and a parallel valid/line vector for coalescing. snoop_tx holds the FSM, drain logic and coalescing match.

Test Plan:
- Single store, 0x8000_0040 wnr=1, peer acks 2 cycles after wvalid -> wvalid rises the cycle after acceptance; snoopy_addr=0x8000_0040 and stays stable until ack; idle=1 the cycle after ack.
- Five stores on consecutive cycles, DEPTH=4, snoop_ack held 0 -> st_ready=0 on the fifth; raise ack -> addresses leave in order at one per cycle, and the fifth is accepted the cycle after the first pop.
- Push and pop in the same cycle while count=2 -> count stays 2, and there is no lost or duplicated address.
- drain_req with 3 entries queued, ack every cycle -> st_ready=0 from the cycle after drain_req; drain_done pulses once, 1 cycle after the last ack; drain_req on an empty FIFO -> drain_done pulses the next cycle.
- SNOOP_COALESCE_EN: hold ack 0, store 0x100, 0x200, 0x204, 0x100 (8-word lines) -> the 0x204 store is dropped and 0x100 is re-enqueued because only the head holds 0x100; count=3. Without the macro -> count=4.
- rst asserted while wvalid=1 with 3 entries queued -> next cycle wvalid=0, idle=1, st_ready=1, drain_done=0.
